// File: rtl/branch_pkg.sv
// Shared branch-unit types: funct3 encodings, 2-bit BHT counter type and reset value,
// plus small helpers for condition validity and saturating counter update.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_cnt_t;

  // Weakly not-taken
  localparam bht_cnt_t BHT_RST = 2'b01;

  function automatic logic f3_is_cond(input logic [2:0] f3);
    return !((f3 == 3'b010) || (f3 == 3'b011));
  endfunction

  function automatic bht_cnt_t cnt_next(input bht_cnt_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : bht_cnt_t'(c + 2'b01);
    else       return (c == 2'b00) ? c : bht_cnt_t'(c - 2'b01);
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters indexed by pc[log2(DEPTH)+1:2].
// Lookup is combinational from the array, so a same-cycle update is not visible until the next cycle.
module branch_bht
  import branch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_lookup_taken,
  input  logic            i_upd_en,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  bht_cnt_t           r_cnt [DEPTH];
  logic [IDX_W-1:0]   w_lk_idx;
  logic [IDX_W-1:0]   w_up_idx;
  logic               w_unused_pc;

  assign w_lk_idx = i_lookup_pc[IDX_W+1:2];
  assign w_up_idx = i_upd_pc[IDX_W+1:2];

  // Low byte-offset and high PC bits do not participate in indexing
  assign w_unused_pc = ^{i_lookup_pc[XLEN-1:IDX_W+2], i_lookup_pc[1:0],
                         i_upd_pc[XLEN-1:IDX_W+2], i_upd_pc[1:0]};

  assign o_lookup_taken = r_cnt[w_lk_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_cnt[i] <= BHT_RST;
    end else if (i_upd_en) begin
      r_cnt[w_up_idx] <= cnt_next(r_cnt[w_up_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates conditions, registers one result with handshake, trains a BHT.
// Optional statistics counters are built only when BRANCH_UNIT_STATS_EN is defined.
module branch_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_is_jump,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_target,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [XLEN-1:0]  out_redirect_pc,
  input  logic             flush,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  logic            r_out_valid;
  logic            r_out_taken;
  logic            r_out_mispredict;
  logic [XLEN-1:0] r_out_redirect_pc;
  logic            w_cond;
  logic            w_taken;
  logic            w_accept;
  logic            w_upd_en;
  logic            w_hs;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_hs     = r_out_valid && out_ready && !flush;

  // Condition evaluation; reserved funct3 codes resolve not-taken
  always_comb begin
    w_cond = 1'b0;
    case (in_funct3)
      F3_BEQ:  w_cond = (in_rs1 == in_rs2);
      F3_BNE:  w_cond = (in_rs1 != in_rs2);
      F3_BLT:  w_cond = ($signed(in_rs1) <  $signed(in_rs2));
      F3_BGE:  w_cond = ($signed(in_rs1) >= $signed(in_rs2));
      F3_BLTU: w_cond = (in_rs1 <  in_rs2);
      F3_BGEU: w_cond = (in_rs1 >= in_rs2);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken  = in_is_jump || w_cond;
  assign w_upd_en = w_accept && !in_is_jump && f3_is_cond(in_funct3);

  // Single-entry output stage; flush wins over both accept and drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid       <= 1'b0;
      r_out_taken       <= 1'b0;
      r_out_mispredict  <= 1'b0;
      r_out_redirect_pc <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid       <= 1'b1;
      r_out_taken       <= w_taken;
      r_out_mispredict  <= w_taken ^ in_pred_taken;
      r_out_redirect_pc <= w_taken ? in_target : XLEN'(in_pc + XLEN'(4));
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid       = r_out_valid;
  assign out_taken       = r_out_taken;
  assign out_mispredict  = r_out_mispredict;
  assign out_redirect_pc = r_out_redirect_pc;

  branch_bht #(
    .XLEN  (XLEN),
    .DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_lookup_pc    (lookup_pc),
    .o_lookup_taken (lookup_taken),
    .i_upd_en       (w_upd_en),
    .i_upd_pc       (in_pc),
    .i_upd_taken    (w_taken)
  );

`ifdef BRANCH_UNIT_STATS_EN
  logic [CNT_W-1:0] r_stat_br;
  logic [CNT_W-1:0] r_stat_mis;

  // Counters only see results actually consumed downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else if (w_hs) begin
      r_stat_br <= CNT_W'(r_stat_br + CNT_W'(1));
      if (r_out_mispredict) r_stat_mis <= CNT_W'(r_stat_mis + CNT_W'(1));
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mis;
`else
  logic w_unused_hs;
  assign w_unused_hs      = w_hs;
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: stimulus pushes expected results, a monitor pops on handshake.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = 3'b000;
  logic        in_is_jump = 1'b0;
  logic        in_pred_taken = 1'b0;
  logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_target = '0;
  logic [31:0] lookup_pc = 32'h100;
  logic        lookup_taken;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_taken;
  logic        out_mispredict;
  logic [31:0] out_redirect_pc;
  logic        flush = 1'b0;
  logic [3:0]  stat_branches, stat_mispredicts;

  typedef struct {
    logic        taken;
    logic        mis;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_br     = 0;
  int   m_mis    = 0;

  branch_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_is_jump(in_is_jump), .in_pred_taken(in_pred_taken),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_target(in_target),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_redirect_pc(out_redirect_pc),
    .flush(flush), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare the held result every cycle, pop on handshake, discard on flush
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 64'(out_valid), 64'(0));
      end else if (flush) begin
        void'(q.pop_front());
      end else begin
        chk("out_taken", 64'(out_taken), 64'(q[0].taken));
        chk("out_mispredict", 64'(out_mispredict), 64'(q[0].mis));
        chk("out_redirect_pc", 64'(out_redirect_pc), 64'(q[0].rpc));
        if (out_ready) begin
          m_br++;
          if (q[0].mis) m_mis++;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic [2:0] f3, input logic jmp, input logic pred,
                       input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] tgt);
    in_funct3 = f3; in_is_jump = jmp; in_pred_taken = pred;
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_target = tgt;
    in_valid = 1'b1;
  endtask

  // lk_b / lk_a: expected lookup_taken just before / after the accepting edge (-1 = skip)
  task automatic issue(input logic [2:0] f3, input logic jmp, input logic pred,
                       input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] tgt,
                       input logic e_taken, input logic e_mis, input logic [31:0] e_rpc,
                       input int lk_b, input int lk_a);
    bit ok = 1'b0;
    drive(f3, jmp, pred, pc, rs1, rs2, tgt);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("in_ready_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
    end else begin
      if (lk_b >= 0) chk("lookup_pre_update", 64'(lookup_taken), 64'(lk_b));
      q.push_back('{e_taken, e_mis, e_rpc});
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (lk_a >= 0) chk("lookup_post_update", 64'(lookup_taken), 64'(lk_a));
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_taken", 64'(out_taken), 64'(0));
    chk("rst_out_mispredict", 64'(out_mispredict), 64'(0));
    chk("rst_redirect", 64'(out_redirect_pc), 64'(0));
    chk("rst_stat_br", 64'(stat_branches), 64'(0));
    chk("rst_stat_mis", 64'(stat_mispredicts), 64'(0));
    chk("rst_bht_weak_nt", 64'(lookup_taken), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("in_ready_after_rst", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Condition coverage, back-to-back with out_ready=1
    issue(3'b100, 1'b0, 1'b0, 32'h1004, 32'hFFFF_FFFF, 32'h1, 32'h1400, 1'b1, 1'b1, 32'h1400, -1, -1);
    chk("one_cycle_latency", 64'(out_valid), 64'(1));
    issue(3'b110, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h1, 32'h1800, 1'b0, 1'b0, 32'h0, -1, -1);
    issue(3'b000, 1'b0, 1'b1, 32'h1008, 32'h5, 32'h5, 32'h1500, 1'b1, 1'b0, 32'h1500, -1, -1);
    issue(3'b001, 1'b0, 1'b1, 32'h100C, 32'h5, 32'h5, 32'h1600, 1'b0, 1'b1, 32'h1010, -1, -1);
    issue(3'b101, 1'b0, 1'b0, 32'h1010, 32'hFFFF_FFFF, 32'h1, 32'h1700, 1'b0, 1'b0, 32'h1014, -1, -1);
    issue(3'b111, 1'b0, 1'b0, 32'h1014, 32'hFFFF_FFFF, 32'h1, 32'h1900, 1'b1, 1'b1, 32'h1900, -1, -1);
    issue(3'b010, 1'b0, 1'b1, 32'h1018, 32'h5, 32'h5, 32'h1A00, 1'b0, 1'b1, 32'h101C, -1, -1);
    issue(3'b001, 1'b1, 1'b0, 32'h101C, 32'h5, 32'h5, 32'h1B00, 1'b1, 1'b1, 32'h1B00, -1, -1);
    issue(3'b100, 1'b0, 1'b0, 32'h1020, 32'h1, 32'hFFFF_FFFF, 32'h1C00, 1'b0, 1'b0, 32'h1024, -1, -1);

    // BHT training at 0x100: 01->10->11->11, down to 00, back to 01; jumps leave it alone
    issue(3'b000, 1'b0, 1'b0, 32'h100, 32'h7, 32'h7, 32'h500, 1'b1, 1'b1, 32'h500, 0, 1);
    issue(3'b000, 1'b0, 1'b0, 32'h100, 32'h7, 32'h7, 32'h500, 1'b1, 1'b1, 32'h500, 1, 1);
    issue(3'b000, 1'b0, 1'b1, 32'h100, 32'h7, 32'h7, 32'h500, 1'b1, 1'b0, 32'h500, 1, 1);
    issue(3'b000, 1'b0, 1'b1, 32'h100, 32'h7, 32'h8, 32'h500, 1'b0, 1'b1, 32'h104, 1, 1);
    issue(3'b000, 1'b0, 1'b1, 32'h100, 32'h7, 32'h8, 32'h500, 1'b0, 1'b1, 32'h104, 1, 0);
    issue(3'b000, 1'b0, 1'b0, 32'h100, 32'h7, 32'h8, 32'h500, 1'b0, 1'b0, 32'h104, 0, 0);
    issue(3'b000, 1'b0, 1'b0, 32'h100, 32'h7, 32'h7, 32'h500, 1'b1, 1'b1, 32'h500, 0, 0);
    issue(3'b000, 1'b1, 1'b1, 32'h100, 32'h7, 32'h8, 32'h600, 1'b1, 1'b0, 32'h600, 0, 0);
    issue(3'b000, 1'b1, 1'b1, 32'h100, 32'h7, 32'h8, 32'h600, 1'b1, 1'b0, 32'h600, 0, 0);
    idle(1);

    // Backpressure: A held 3 cycles, B accepted the cycle out_ready rises
    out_ready = 1'b0;
    issue(3'b101, 1'b0, 1'b1, 32'h1030, 32'h10, 32'hFFFF_FFF0, 32'h1130, 1'b1, 1'b0, 32'h1130, -1, -1);
    drive(3'b110, 1'b0, 1'b0, 32'h1034, 32'h3, 32'h4, 32'h1134);
    repeat (3) begin
      @(negedge clk);
      chk("in_ready_stalled", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_released", 64'(in_ready), 64'(1));
    q.push_back('{1'b1, 1'b1, 32'h1134});
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);

    // Flush with a held result and a same-cycle accept that would train 0x100
    out_ready = 1'b0;
    issue(3'b001, 1'b0, 1'b1, 32'h2008, 32'h1, 32'h2, 32'h2100, 1'b1, 1'b0, 32'h2100, -1, -1);
    drive(3'b000, 1'b0, 1'b0, 32'h100, 32'h9, 32'h9, 32'h700);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_bht_unchanged", 64'(lookup_taken), 64'(0));
`ifdef BRANCH_UNIT_STATS_EN
    chk("flush_stat_br", 64'(stat_branches), 64'(m_br % 16));
    chk("flush_stat_mis", 64'(stat_mispredicts), 64'(m_mis % 16));
`else
    chk("flush_stat_br", 64'(stat_branches), 64'(0));
    chk("flush_stat_mis", 64'(stat_mispredicts), 64'(0));
`endif
    idle(1);

    // Reset while a result is held: dropped without output
    out_ready = 1'b0;
    issue(3'b000, 1'b0, 1'b1, 32'h2004, 32'h1, 32'h1, 32'h2200, 1'b1, 1'b0, 32'h2200, -1, -1);
    rst_n = 1'b0;
    q.delete();
    m_br = 0; m_mis = 0;
    #2;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_redirect", 64'(out_redirect_pc), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("midrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // 17 handshakes with 2 mispredicts; a 4-bit branch counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      logic p;
      p = (i == 5 || i == 11) ? 1'b0 : 1'b1;
      issue(3'b000, 1'b0, p, 32'h3004 + 32'(4 * i), 32'h1, 32'h1, 32'h3800, 1'b1, !p, 32'h3800, -1, -1);
    end
    idle(3);
`ifdef BRANCH_UNIT_STATS_EN
    chk("stat_branches_wrap", 64'(stat_branches), 64'(1));
    chk("stat_mispredicts", 64'(stat_mispredicts), 64'(2));
`else
    chk("stat_branches_off", 64'(stat_branches), 64'(0));
    chk("stat_mispredicts_off", 64'(stat_mispredicts), 64'(0));
`endif
    chk("scoreboard_drained", 64'(q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
